// File: rtl/gin_row_receiver.sv
// gin_row_receiver: row-level GIN endpoint that matches X/Y tags against scanned IDs and multicasts payloads to PEs
module gin_row_receiver #(
  parameter int NUMS_PE_COL = 8,
  parameter int XID_BITS    = 4,
  parameter int YID_BITS    = 3,
  parameter int DATA_SIZE   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_XID,
  input  logic [XID_BITS-1:0]    XID_scan_in,
  input  logic                   set_YID,
  input  logic [YID_BITS-1:0]    YID_scan_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_SIZE-1:0]   in_data,
  input  logic [XID_BITS-1:0]    tag_X,
  input  logic [YID_BITS-1:0]    tag_Y,
  output logic [NUMS_PE_COL-1:0] PE_valid,
  input  logic [NUMS_PE_COL-1:0] PE_ready,
  output logic [DATA_SIZE-1:0]   PE_data,
  output logic [15:0]            deliver_cnt,
  output logic [15:0]            drop_cnt
);
  typedef enum logic {IDLE, DELIVER} state_t;
  state_t                 state_q, state_d;
  logic [XID_BITS-1:0]    xid_q [NUMS_PE_COL];
  logic [XID_BITS-1:0]    xid_d [NUMS_PE_COL];
  logic [YID_BITS-1:0]    yid_q, yid_d;
  logic [NUMS_PE_COL-1:0] pend_q, pend_d, mask;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic [15:0]            dcnt_q, dcnt_d, xcnt_q, xcnt_d;
  logic                   row_hit;
  assign row_hit = tag_Y == yid_q;
  for (genvar i = 0; i < NUMS_PE_COL; i++) begin : g_mask
    assign mask[i] = row_hit && (xid_q[i] == tag_X);
  end
  // Column-ID shift chain and row-ID load; independent of the delivery FSM
  always_comb begin
    xid_d = xid_q;
    yid_d = set_YID ? YID_scan_in : yid_q;
    if (set_XID) begin
      xid_d[0] = XID_scan_in;
      for (int k = 1; k < NUMS_PE_COL; k++) xid_d[k] = xid_q[k-1];
    end
  end
  // Accept/drop in IDLE, drain the pending mask in DELIVER
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    data_d  = data_q;
    dcnt_d  = dcnt_q;
    xcnt_d  = xcnt_q;
    if (state_q == IDLE) begin
      if (in_valid && |mask) begin
        pend_d  = mask;
        data_d  = in_data;
        state_d = DELIVER;
      end else if (in_valid) begin
        xcnt_d = xcnt_q + 16'd1;
      end
    end else begin
      pend_d = pend_q & ~PE_ready;
      if (pend_d == '0) begin
        state_d = IDLE;
        dcnt_d  = dcnt_q + 16'd1;
      end
    end
  end
  // State registers; reset abandons any in-flight packet and restores all-ones IDs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      data_q  <= '0;
      dcnt_q  <= '0;
      xcnt_q  <= '0;
      yid_q   <= '1;
      for (int k = 0; k < NUMS_PE_COL; k++) xid_q[k] <= '1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      dcnt_q  <= dcnt_d;
      xcnt_q  <= xcnt_d;
      yid_q   <= yid_d;
      xid_q   <= xid_d;
    end
  end
  assign in_ready    = state_q == IDLE;
  assign PE_valid    = state_q == DELIVER ? pend_q : '0;
  assign PE_data     = data_q;
  assign deliver_cnt = dcnt_q;
  assign drop_cnt    = xcnt_q;
endmodule
